// File: rtl/instr_encoder.sv
// instr_encoder: packs LDUR/STUR/CBZ requests into 32-bit LEGv8 words and
// streams them to instruction memory with a wrapping byte address.
// Requests whose immediate does not fit the instruction field, and requests
// with the reserved op, put the block into a sticky error state. It leaves
// that state only on err_clr or on reset.
module instr_encoder #(
    parameter int unsigned DEPTH = 64,
    parameter logic [63:0] BASE  = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rn,
    input  logic [63:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_addr,
    output logic        err,
    output logic [1:0]  err_code,
    input  logic        err_clr,
    output logic [31:0] count
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EMIT = 2'b01,
        ERR  = 2'b10
    } state_t;

    // First byte address past the imem window; out_addr wraps when it gets here.
    localparam logic [63:0] WRAP_ADDR = BASE + (64'(DEPTH) * 64'd4);

    // Field packing. Only the low immediate bits land in the word; the range
    // check makes sure the dropped upper bits are pure sign extension.
    function automatic logic [31:0] encode(input logic [1:0]  op,
                                           input logic [4:0]  rt,
                                           input logic [4:0]  rn,
                                           input logic [63:0] imm);
        logic [31:0] word;
        case (op)
            2'b00:   word = {11'h7C2, imm[8:0], 2'b00, rn, rt};
            2'b01:   word = {11'h7C0, imm[8:0], 2'b00, rn, rt};
            2'b10:   word = {8'hB4, imm[18:0], rt};
            default: word = 32'h0000_0000;
        endcase
        return word;
    endfunction

    // True when the immediate survives the round trip through the sign extender.
    function automatic logic imm_fits(input logic [1:0] op, input logic [63:0] imm);
        logic fits;
        case (op)
            2'b00, 2'b01: fits = (imm[63:8] == {56{imm[8]}});
            2'b10:        fits = (imm[63:18] == {46{imm[18]}});
            default:      fits = 1'b0;
        endcase
        return fits;
    endfunction

    state_t      state_r;
    state_t      next_state_s;
    logic        accept_s;
    logic        out_hs_s;
    logic        op_rsv_s;
    logic        legal_s;
    logic [63:0] addr_inc_s;
    logic [63:0] addr_next_s;

    assign accept_s   = in_valid & in_ready;
    assign out_hs_s   = (state_r == EMIT) & out_ready;
    assign op_rsv_s   = (in_op == 2'b11);
    assign legal_s    = ~op_rsv_s & imm_fits(in_op, in_imm);
    assign addr_inc_s = out_addr + 64'd4;
    assign out_valid  = (state_r == EMIT);

    // Wrap the next address back to BASE at the end of the imem window.
    always_comb begin
        if (addr_inc_s == WRAP_ADDR) begin
            addr_next_s = BASE;
        end else begin
            addr_next_s = addr_inc_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; in EMIT an accepted request implies a handshake, so no bubble.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = legal_s ? EMIT : ERR;
                end else begin
                    next_state_s = IDLE;
                end
            end
            EMIT: begin
                if (accept_s) begin
                    next_state_s = legal_s ? EMIT : ERR;
                end else if (out_hs_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = EMIT;
                end
            end
            ERR: begin
                if (err_clr) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = ERR;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Upstream ready: held low during reset and in ERR, and follows the sink while a word is held.
    always_comb begin
        in_ready = 1'b0;
        if (!reset) begin
            in_ready = 1'b0;
        end else begin
            case (state_r)
                IDLE:    in_ready = 1'b1;
                EMIT:    in_ready = out_ready;
                ERR:     in_ready = 1'b0;
                default: in_ready = 1'b0;
            endcase
        end
    end

    // Datapath registers: the encoded word, the imem address, the emitted count and the sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_instr <= 32'h0000_0000;
            out_addr  <= BASE;
            count     <= 32'd0;
            err       <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            if (accept_s && legal_s) begin
                out_instr <= encode(in_op, in_rt, in_rn, in_imm);
            end
            if (out_hs_s) begin
                out_addr <= addr_next_s;
                count    <= count + 32'd1;
            end
            if (accept_s && !legal_s) begin
                err      <= 1'b1;
                err_code <= op_rsv_s ? 2'b10 : 2'b01;
            end else if ((state_r == ERR) && err_clr) begin
                err      <= 1'b0;
                err_code <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (built with DEPTH=4 so the address wrap is exercised).
// A transaction-level model tracks the held word, words emitted and the error flag.
// A negedge process compares every output to it. The directed sequence adds literal checks.
module tb_instr_encoder;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'b00;
    logic [4:0]  in_rt = 5'd0;
    logic [4:0]  in_rn = 5'd0;
    logic [63:0] in_imm = 64'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [63:0] out_addr;
    logic        err;
    logic [1:0]  err_code;
    logic        err_clr = 1'b0;
    logic [31:0] count;

    int tests = 0;
    int fails = 0;
    bit started = 1'b0;

    instr_encoder #(.DEPTH(DEPTH), .BASE(64'h0)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rt(in_rt), .in_rn(in_rn), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err(err), .err_code(err_code), .err_clr(err_clr),
        .count(count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          m_held = 1'b0;
    logic [31:0] m_word = 32'd0;
    longint      m_count = 0;
    bit          m_err = 1'b0;
    int          m_code = 0;

    function automatic bit m_legal(input int op, input longint imm);
        if (op == 0 || op == 1) return (imm >= -256) && (imm <= 255);
        if (op == 2) return (imm >= -262144) && (imm <= 262143);
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_encode(input int op, input int rt, input int rn, input longint imm);
        logic [31:0] f9;
        logic [31:0] f19;
        f9  = 32'(imm & 64'h1FF);
        f19 = 32'(imm & 64'h7FFFF);
        if (op == 0) return 32'hF840_0000 | (f9 << 12) | 32'(rn << 5) | 32'(rt);
        if (op == 1) return 32'hF800_0000 | (f9 << 12) | 32'(rn << 5) | 32'(rt);
        return 32'hB400_0000 | (f19 << 5) | 32'(rt);
    endfunction

    function automatic bit m_ready();
        if (!reset) return 1'b0;
        return !m_err && (!m_held || out_ready);
    endfunction

    function automatic logic [63:0] m_addr();
        return 64'((m_count % DEPTH) * 4);
    endfunction

    // Sign extender used to confirm the round trip of emitted words.
    function automatic longint signext(input logic [31:0] w);
        logic [18:0] c;
        logic [8:0]  d;
        c = w[23:5];
        d = w[20:12];
        if (w[31:24] == 8'hB4) return longint'($signed(c));
        return longint'($signed(d));
    endfunction

    // Model update: consume the handshakes seen at each rising edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_held  = 1'b0;
            m_count = 0;
            m_err   = 1'b0;
            m_code  = 0;
        end else begin
            bit rdy;
            bit acc;
            rdy = !m_err && (!m_held || out_ready);
            acc = in_valid && rdy;
            if (m_held && out_ready) begin
                m_count = m_count + 1;
                m_held  = 1'b0;
            end
            if (m_err && err_clr) begin
                m_err  = 1'b0;
                m_code = 0;
            end
            if (acc) begin
                if (m_legal(int'(in_op), longint'(in_imm))) begin
                    m_held = 1'b1;
                    m_word = m_encode(int'(in_op), int'(in_rt), int'(in_rn), longint'(in_imm));
                end else begin
                    m_err  = 1'b1;
                    m_code = (in_op == 2'b11) ? 2 : 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: all outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (started) begin
            check("m_in_ready", 64'(in_ready), 64'(m_ready()));
            check("m_out_valid", 64'(out_valid), 64'(m_held));
            check("m_out_addr", out_addr, m_addr());
            check("m_count", 64'(count), 64'(m_count));
            check("m_err", 64'(err), 64'(m_err));
            check("m_err_code", 64'(err_code), 64'(m_code));
            if (m_held) check("m_out_instr", 64'(out_instr), 64'(m_word));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic v, input logic [1:0] op, input logic [4:0] rt,
                       input logic [4:0] rn, input longint imm);
        in_valid = v;
        in_op    = op;
        in_rt    = rt;
        in_rn    = rn;
        in_imm   = 64'(imm);
    endtask

    initial begin
        #1 reset = 1'b0;
        started = 1'b1;
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        reset = 1'b1;
        #1;
        check("rel_in_ready", 64'(in_ready), 64'd1);
        check("rel_out_valid", 64'(out_valid), 64'd0);
        check("rel_out_addr", out_addr, 64'h0);
        check("rel_count", 64'(count), 64'd0);
        check("rel_err", 64'(err), 64'd0);

        // LDUR held by a stalled sink; a pending STUR must wait.
        out_ready = 1'b0;
        req(1'b1, 2'b00, 5'd1, 5'd2, -8);
        tick();
        req(1'b1, 2'b01, 5'd3, 5'd4, 16);
        check("ldur_word", 64'(out_instr), 64'hF85F8041);
        check("ldur_addr", out_addr, 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_word", 64'(out_instr), 64'hF85F8041);
            check("stall_addr", out_addr, 64'h0);
            check("stall_in_ready", 64'(in_ready), 64'd0);
        end

        // Release the sink: back-to-back words, one per cycle.
        out_ready = 1'b1;
        tick();
        check("stur_word", 64'(out_instr), 64'hF8010083);
        check("stur_addr", out_addr, 64'h4);
        req(1'b1, 2'b10, 5'd5, 5'd0, 3);
        tick();
        check("cbz3_word", 64'(out_instr), 64'hB4000065);
        check("cbz3_addr", out_addr, 64'h8);
        check("cbz3_signext", 64'(signext(out_instr)), 64'(longint'(3)));
        req(1'b1, 2'b10, 5'd5, 5'd0, -1);
        tick();
        check("cbzm1_word", 64'(out_instr), 64'hB4FFFFE5);
        check("cbzm1_addr", out_addr, 64'hC);
        check("cbzm1_signext", 64'(signext(out_instr)), 64'(longint'(-1)));
        req(1'b0, 2'b00, 5'd0, 5'd0, 0);
        tick();
        check("wrap_addr", out_addr, 64'h0);
        check("wrap_count4", 64'(count), 64'd4);
        check("wrap_idle", 64'(out_valid), 64'd0);

        // Fifth word lands at the wrapped address; imm=255 is the top of the D range.
        req(1'b1, 2'b00, 5'd6, 5'd7, 255);
        tick();
        req(1'b0, 2'b00, 5'd0, 5'd0, 0);
        check("fifth_addr", out_addr, 64'h0);
        check("fifth_word", 64'(out_instr), 64'hF84FF0E6);
        tick();
        check("count5", 64'(count), 64'd5);

        // Out-of-range immediate, then clear with a request that must be ignored.
        req(1'b1, 2'b00, 5'd1, 5'd1, 256);
        tick();
        check("oor_err", 64'(err), 64'd1);
        check("oor_code", 64'(err_code), 64'd1);
        check("oor_valid", 64'(out_valid), 64'd0);
        check("oor_addr", out_addr, 64'h4);
        check("oor_in_ready", 64'(in_ready), 64'd0);
        req(1'b1, 2'b00, 5'd1, 5'd1, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_err", 64'(err), 64'd0);
        check("clr_code", 64'(err_code), 64'd0);
        check("clr_no_accept", 64'(out_valid), 64'd0);
        check("clr_in_ready", 64'(in_ready), 64'd1);

        // Reserved op wins regardless of imm.
        req(1'b1, 2'b11, 5'd0, 5'd0, 0);
        tick();
        req(1'b0, 2'b00, 5'd0, 5'd0, 0);
        check("rsv_code", 64'(err_code), 64'd2);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // STUR at the bottom of the D range, then retire it alongside an illegal CBZ.
        out_ready = 1'b0;
        req(1'b1, 2'b01, 5'd0, 5'd0, -256);
        tick();
        check("stur_min_word", 64'(out_instr), 64'hF8100000);
        req(1'b1, 2'b10, 5'd2, 5'd0, 262144);
        out_ready = 1'b1;
        tick();
        req(1'b0, 2'b00, 5'd0, 5'd0, 0);
        check("retire_err", 64'(err), 64'd1);
        check("retire_addr", out_addr, 64'h8);
        check("retire_count", 64'(count), 64'd6);
        check("retire_valid", 64'(out_valid), 64'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // CBZ at the bottom of the CB range; err_clr while holding it is ignored.
        out_ready = 1'b0;
        req(1'b1, 2'b10, 5'd31, 5'd0, -262144);
        tick();
        req(1'b0, 2'b00, 5'd0, 5'd0, 0);
        check("cbz_min_word", 64'(out_instr), 64'hB480001F);
        check("cbz_min_signext", 64'(signext(out_instr)), 64'(longint'(-262144)));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_ignored_valid", 64'(out_valid), 64'd1);
        check("clr_ignored_err", 64'(err), 64'd0);

        // Reset in the middle of EMIT takes effect without a clock edge.
        #1 reset = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_addr", out_addr, 64'h0);
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        reset = 1'b1;
        out_ready = 1'b1;
        tick();
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
